// File: rtl/brq_pkg.sv
// Shared types for the brq instruction-fetch path.
// Fetch source IDs tag each granted transaction so its response can be routed back.
package brq_pkg;

    typedef enum logic {
        SRC_IFU = 1'b0,
        SRC_AUX = 1'b1
    } ifetch_src_e;

endpackage

// File: rtl/brq_ifetch_src_fifo.sv
// In-order FIFO of 1-bit source IDs for granted-but-unanswered fetches.
// Pointers wrap modulo Depth; the caller never pushes when full or pops when empty.
module brq_ifetch_src_fifo #(
    parameter int Depth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push,
    input  logic                         din,
    input  logic                         pop,
    output logic                         dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(Depth+1)-1:0]   count
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= din;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!push && pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    assign dout  = mem_q[rptr_q];
    assign full  = (cnt_q == CntW'(Depth));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/brq_ifetch_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between the IFU and an aux fetcher.
// Responses are routed in order using a FIFO of source IDs recorded at grant time.
module brq_ifetch_arbiter
    import brq_pkg::*;
#(
    parameter int MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        busy_o,
    output logic        proto_err_o
);

    localparam int CntW = $clog2(MaxOutstanding + 1);

    ifetch_src_e     sel, last_q, lock_sel_q, head;
    logic            lock_q, locked_req, gnt_fire, rsp_fire;
    logic            full, empty, head_bit, proto_err_q;
    logic [CntW-1:0] count;

    assign locked_req = (lock_sel_q == SRC_IFU) ? m0_req_i : m1_req_i;

    // A stalled request keeps its address until granted, unless its master withdraws it.
    always_comb begin
        sel = SRC_IFU;
        if (lock_q && locked_req)        sel = lock_sel_q;
        else if (m0_req_i && !m1_req_i)  sel = SRC_IFU;
        else if (m1_req_i && !m0_req_i)  sel = SRC_AUX;
        else if (m0_req_i && m1_req_i)   sel = (last_q == SRC_IFU) ? SRC_AUX : SRC_IFU;
    end

    assign mem_req_o  = (m0_req_i | m1_req_i) & ~full;
    assign mem_addr_o = (sel == SRC_AUX) ? m1_addr_i : m0_addr_i;
    assign gnt_fire   = mem_req_o & mem_gnt_i;
    assign m0_gnt_o   = gnt_fire & (sel == SRC_IFU);
    assign m1_gnt_o   = gnt_fire & (sel == SRC_AUX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q      <= 1'b0;
            lock_sel_q  <= SRC_IFU;
            last_q      <= SRC_AUX;
            proto_err_q <= 1'b0;
        end else begin
            if (gnt_fire) begin
                lock_q <= 1'b0;
                last_q <= sel;
            end else if (mem_req_o) begin
                lock_q     <= 1'b1;
                lock_sel_q <= sel;
            end else if (lock_q && !locked_req) begin
                lock_q <= 1'b0;
            end
            if (mem_rvalid_i && empty) proto_err_q <= 1'b1;
        end
    end

    brq_ifetch_src_fifo #(
        .Depth (MaxOutstanding)
    ) u_src_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (gnt_fire),
        .din    (sel),
        .pop    (rsp_fire),
        .dout   (head_bit),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    assign head        = ifetch_src_e'(head_bit);
    assign rsp_fire    = mem_rvalid_i & ~empty;
    assign m0_rvalid_o = rsp_fire & (head == SRC_IFU);
    assign m1_rvalid_o = rsp_fire & (head == SRC_AUX);
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;
    assign m0_err_o    = mem_err_i;
    assign m1_err_o    = mem_err_i;

    assign busy_o      = (count != '0) | m0_req_i | m1_req_i;
    assign proto_err_o = proto_err_q;

    // A response with nothing outstanding means memory and this block disagree on state.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(mem_rvalid_i && empty))
                else $warning("brq_ifetch_arbiter: rvalid with no outstanding fetch");
        end
    end

endmodule

// File: tb/tb_brq_ifetch_arbiter.sv
// Self-checking bench for brq_ifetch_arbiter: per-cycle vector table plus scoreboarded response routing.
module tb_brq_ifetch_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0010;
    localparam logic [31:0] A1 = 32'h0000_0020;

    logic        clk = 1'b0, rst_ni = 1'b0;
    logic        m0_req_i = 0, m1_req_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0, mem_err_i = 0;
    logic [31:0] m0_addr_i = 0, m1_addr_i = 0, mem_rdata_i = 0;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic        mem_req_o, busy_o, proto_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o, mem_addr_o;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    brq_ifetch_arbiter #(.MaxOutstanding(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    typedef struct {
        logic rst; logic m0r; logic [31:0] a0; logic m1r; logic [31:0] a1;
        logic gnt; logic rv; logic [31:0] rd; logic err;
        logic e_req; logic [31:0] e_addr;
        logic e_g0, e_g1, e_rv0, e_rv1, e_busy, e_perr;
    } vec_t;

    typedef struct { logic src; } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];

    function automatic vec_t v(logic rst, logic m0r, logic [31:0] a0, logic m1r, logic [31:0] a1,
                               logic gnt, logic rv, logic [31:0] rd, logic err,
                               logic e_req, logic [31:0] e_addr, logic e_g0, logic e_g1,
                               logic e_rv0, logic e_rv1, logic e_busy, logic e_perr);
        vec_t t;
        t.rst = rst; t.m0r = m0r; t.a0 = a0; t.m1r = m1r; t.a1 = a1;
        t.gnt = gnt; t.rv = rv; t.rd = rd; t.err = err;
        t.e_req = e_req; t.e_addr = e_addr; t.e_g0 = e_g0; t.e_g1 = e_g1;
        t.e_rv0 = e_rv0; t.e_rv1 = e_rv1; t.e_busy = e_busy; t.e_perr = e_perr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic m0r, input logic [31:0] a0, input logic m1r, input logic [31:0] a1,
                         input logic gnt, input logic rv, input logic [31:0] rd, input logic err);
        m0_req_i = m0r; m0_addr_i = a0; m1_req_i = m1r; m1_addr_i = a1;
        mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rd; mem_err_i = err;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t t, input int i);
        if (t.rst) do_reset();
        drive(t.m0r, t.a0, t.m1r, t.a1, t.gnt, t.rv, t.rd, t.err);
        @(negedge clk);
        chk($sformatf("v%0d mem_req", i), mem_req_o, t.e_req);
        if (t.e_req) chk($sformatf("v%0d mem_addr", i), mem_addr_o, t.e_addr);
        chk($sformatf("v%0d m0_gnt", i), m0_gnt_o, t.e_g0);
        chk($sformatf("v%0d m1_gnt", i), m1_gnt_o, t.e_g1);
        chk($sformatf("v%0d m0_rvalid", i), m0_rvalid_o, t.e_rv0);
        chk($sformatf("v%0d m1_rvalid", i), m1_rvalid_o, t.e_rv1);
        chk($sformatf("v%0d busy", i), busy_o, t.e_busy);
        chk($sformatf("v%0d proto_err", i), proto_err_o, t.e_perr);
        if (t.e_rv0) begin
            chk($sformatf("v%0d m0_rdata", i), m0_rdata_o, t.rd);
            chk($sformatf("v%0d m0_err", i), m0_err_o, t.err);
        end
        if (t.e_rv1) begin
            chk($sformatf("v%0d m1_rdata", i), m1_rdata_o, t.rd);
            chk($sformatf("v%0d m1_err", i), m1_err_o, t.err);
        end
        @(posedge clk);
        #1;
    endtask

    // exp_g: 0 no grant expected, 1 grant to m0, 2 grant to m1
    task automatic cyc(input logic m0r, input logic [31:0] a0, input logic m1r, input logic [31:0] a1,
                       input logic gnt, input logic rv, input logic [31:0] rd, input logic err,
                       input int exp_g);
        sb_t e;
        logic has = 1'b0;
        drive(m0r, a0, m1r, a1, gnt, rv, rd, err);
        @(negedge clk);
        if (rv) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_underflow: got rvalid expected none outstanding");
            end else begin
                e = sb.pop_front();
                has = 1'b1;
            end
        end
        chk("sb m0_rvalid", m0_rvalid_o, has && !e.src);
        chk("sb m1_rvalid", m1_rvalid_o, has && e.src);
        if (has && !e.src) begin
            chk("sb m0_rdata", m0_rdata_o, rd);
            chk("sb m0_err", m0_err_o, err);
        end
        if (has && e.src) begin
            chk("sb m1_rdata", m1_rdata_o, rd);
            chk("sb m1_err", m1_err_o, err);
        end
        chk("sb m0_gnt", m0_gnt_o, exp_g == 1);
        chk("sb m1_gnt", m1_gnt_o, exp_g == 2);
        if (exp_g != 0) begin
            chk("sb mem_addr", mem_addr_o, (exp_g == 1) ? a0 : a1);
            e.src = (exp_g == 2);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        tbl.push_back(v(1, 0,0,  0,0,  0,0,0,0,        0,0,  0,0,0,0, 0,0));
        // single IFU fetch and its response
        tbl.push_back(v(0, 1,'h80, 0,0, 1,0,0,0,       1,'h80, 1,0,0,0, 1,0));
        tbl.push_back(v(0, 0,0,  0,0,  0,1,'h13,0,     0,0,  0,0,1,0, 1,0));
        // round robin with immediate responses
        tbl.push_back(v(1, 1,A0, 1,A1, 1,0,0,0,        1,A0, 1,0,0,0, 1,0));
        tbl.push_back(v(0, 1,A0, 1,A1, 1,1,'hA,0,      1,A1, 0,1,1,0, 1,0));
        tbl.push_back(v(0, 1,A0, 1,A1, 1,1,'hB,0,      1,A0, 1,0,0,1, 1,0));
        tbl.push_back(v(0, 1,A0, 1,A1, 1,1,'hC,0,      1,A1, 0,1,1,0, 1,0));
        tbl.push_back(v(0, 0,0,  0,0,  0,1,'hD,0,      0,0,  0,0,0,1, 1,0));
        tbl.push_back(v(0, 0,0,  0,0,  0,0,0,0,        0,0,  0,0,0,0, 0,0));
        // stalled grant holds m0 address, then m1 is next
        tbl.push_back(v(1, 1,A0, 1,A1, 0,0,0,0,        1,A0, 0,0,0,0, 1,0));
        tbl.push_back(v(0, 1,A0, 1,A1, 0,0,0,0,        1,A0, 0,0,0,0, 1,0));
        tbl.push_back(v(0, 1,A0, 1,A1, 0,0,0,0,        1,A0, 0,0,0,0, 1,0));
        tbl.push_back(v(0, 1,A0, 1,A1, 1,0,0,0,        1,A0, 1,0,0,0, 1,0));
        tbl.push_back(v(0, 1,A0, 1,A1, 0,0,0,0,        1,A1, 0,0,0,0, 1,0));
        tbl.push_back(v(0, 0,0,  0,0,  0,1,'hE,0,      0,0,  0,0,1,0, 1,0));
        // lock overrides round robin; a dropped locked request is released silently
        tbl.push_back(v(1, 0,0,  1,A1, 0,0,0,0,        1,A1, 0,0,0,0, 1,0));
        tbl.push_back(v(0, 1,A0, 1,A1, 0,0,0,0,        1,A1, 0,0,0,0, 1,0));
        tbl.push_back(v(0, 1,A0, 1,A1, 1,0,0,0,        1,A1, 0,1,0,0, 1,0));
        tbl.push_back(v(0, 0,0,  1,A1, 0,0,0,0,        1,A1, 0,0,0,0, 1,0));
        tbl.push_back(v(0, 1,A0, 0,0,  0,0,0,0,        1,A0, 0,0,0,0, 1,0));
        tbl.push_back(v(0, 0,0,  0,0,  0,1,'hF,1,      0,0,  0,0,0,1, 1,0));
        // full FIFO blocks requests, even while a response pops
        tbl.push_back(v(1, 1,A0, 0,0,  1,0,0,0,        1,A0, 1,0,0,0, 1,0));
        tbl.push_back(v(0, 1,A0, 0,0,  1,0,0,0,        1,A0, 1,0,0,0, 1,0));
        tbl.push_back(v(0, 1,A0, 0,0,  1,0,0,0,        0,0,  0,0,0,0, 1,0));
        tbl.push_back(v(0, 1,A0, 0,0,  1,1,'h21,0,     0,0,  0,0,1,0, 1,0));
        tbl.push_back(v(0, 1,A0, 0,0,  1,0,0,0,        1,A0, 1,0,0,0, 1,0));
        tbl.push_back(v(0, 0,0,  0,0,  0,1,'h22,0,     0,0,  0,0,1,0, 1,0));
        tbl.push_back(v(0, 0,0,  0,0,  0,1,'h23,0,     0,0,  0,0,1,0, 1,0));
        tbl.push_back(v(0, 0,0,  0,0,  0,0,0,0,        0,0,  0,0,0,0, 0,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // in-order routing with an error on the middle response
        do_reset();
        sb.delete();
        cyc(1, 'h100, 0, 0,      1, 0, 0,          0, 1);
        cyc(0, 0,     1, 'h200,  1, 0, 0,          0, 2);
        cyc(0, 0,     0, 0,      0, 1, 'h1111,     0, 0);
        cyc(1, 'h104, 0, 0,      1, 1, 'h2222,     1, 1);
        cyc(0, 0,     0, 0,      0, 1, 'h3333,     0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sb drained busy", busy_o, 1'b0);
        chk("sb proto_err", proto_err_o, 1'b0);

        // stray response sets sticky protocol error; async reset clears it
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 'hDEAD, 0);
        @(negedge clk);
        chk("stray m0_rvalid", m0_rvalid_o, 1'b0);
        chk("stray m1_rvalid", m1_rvalid_o, 1'b0);
        chk("stray proto_err pre", proto_err_o, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("stray proto_err set", proto_err_o, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("stray proto_err held", proto_err_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async rst proto_err", proto_err_o, 1'b0);
        chk("async rst busy", busy_o, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
